// File: rtl/sample_sequencer.sv
// ADC sample sequencer: paced conversion requests, bias calibration over 2^CAL_LOG2 samples,
// then offset-corrected signed sample stream. Optional SAMPLE_OVERRUN_COUNT_EN adds a dropped-tick counter.
module sample_sequencer #(
    parameter int SAMPLE_DIV = 1250,
    parameter int CAL_LOG2   = 12,
    parameter int W          = 10
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         recal,
    output logic         adcReq,
    input  logic         adcDone,
    input  logic [W-1:0] adcData,
    output logic [W-1:0] offset,
    output logic         calibrated,
    output logic [W:0]   sampleOut,
    output logic         sampleValid
`ifdef SAMPLE_OVERRUN_COUNT_EN
    ,
    output logic [7:0]   overrunCount
`endif
);
    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int AW = W + CAL_LOG2;
    localparam int CW = CAL_LOG2 + 1;

    typedef enum logic [1:0] {CAL_IDLE, CAL_WAIT, RUN_IDLE, RUN_WAIT} state_t;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic          tick;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;
    logic [CW-1:0] calcnt;
    logic [CW-1:0] cnt_nxt;
    logic          cal_last;

    assign tick     = (tcnt == TW'(SAMPLE_DIV - 1));
    assign acc_sum  = acc + AW'(adcData);
    assign cnt_nxt  = calcnt + 1'b1;
    assign cal_last = (cnt_nxt == CW'(1 << CAL_LOG2));

    // Sample pacing runs independently of calibration state and recal.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)   tcnt <= '0;
        else if (tick) tcnt <= '0;
        else           tcnt <= tcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= CAL_IDLE;
            adcReq      <= 1'b0;
            acc         <= '0;
            calcnt      <= '0;
            offset      <= '0;
            calibrated  <= 1'b0;
            sampleOut   <= '0;
            sampleValid <= 1'b0;
        end else begin
            adcReq      <= 1'b0;
            sampleValid <= 1'b0;
            if (recal) begin
                // Offset is kept so downstream sees the old estimate until a new one exists.
                state      <= CAL_IDLE;
                acc        <= '0;
                calcnt     <= '0;
                calibrated <= 1'b0;
            end else begin
                case (state)
                    CAL_IDLE: if (tick) begin
                        adcReq <= 1'b1;
                        state  <= CAL_WAIT;
                    end
                    CAL_WAIT: if (adcDone) begin
                        acc    <= acc_sum;
                        calcnt <= cnt_nxt;
                        if (cal_last) begin
                            offset     <= acc_sum[AW-1:CAL_LOG2];
                            calibrated <= 1'b1;
                            state      <= RUN_IDLE;
                        end else begin
                            state <= CAL_IDLE;
                        end
                    end
                    RUN_IDLE: if (tick) begin
                        adcReq <= 1'b1;
                        state  <= RUN_WAIT;
                    end
                    RUN_WAIT: if (adcDone) begin
                        sampleOut   <= {1'b0, adcData} - {1'b0, offset};
                        sampleValid <= 1'b1;
                        state       <= RUN_IDLE;
                    end
                    default: state <= CAL_IDLE;
                endcase
            end
        end
    end

`ifdef SAMPLE_OVERRUN_COUNT_EN
    // A tick seen while a conversion is outstanding is dropped and counted.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            overrunCount <= '0;
        else if (recal)
            overrunCount <= '0;
        else if (tick && (state == CAL_WAIT || state == RUN_WAIT) && overrunCount != 8'hFF)
            overrunCount <= overrunCount + 1'b1;
    end
`endif

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer with SAMPLE_DIV=8, CAL_LOG2=2, W=10.
module tb_sample_sequencer;
    logic        clk = 1'b0;
    logic        resetN;
    logic        recal;
    logic        adcReq;
    logic        adcDone;
    logic [9:0]  adcData;
    logic [9:0]  offset;
    logic        calibrated;
    logic [10:0] sampleOut;
    logic        sampleValid;
`ifdef SAMPLE_OVERRUN_COUNT_EN
    logic [7:0]  overrunCount;
`endif

    int total = 0;
    int fails = 0;
    int reqCount = 0;
    int svSeen = 0;

    sample_sequencer #(.SAMPLE_DIV(8), .CAL_LOG2(2), .W(10)) dut (
        .clk(clk), .resetN(resetN), .recal(recal), .adcReq(adcReq),
        .adcDone(adcDone), .adcData(adcData), .offset(offset),
        .calibrated(calibrated), .sampleOut(sampleOut), .sampleValid(sampleValid)
`ifdef SAMPLE_OVERRUN_COUNT_EN
        , .overrunCount(overrunCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        if (sampleValid === 1'b1) svSeen++;
        if (adcReq === 1'b1) reqCount++;
    endtask

    task automatic wait_req(output int n);
        logic got;
        n = 0;
        got = 1'b0;
        repeat (40) if (!got) begin
            step;
            n++;
            got = (adcReq === 1'b1);
        end
        chk("req_seen", {31'b0, got}, 1);
    endtask

    // Respond to a request just seen: done two cycles after the request.
    task automatic conv(input logic [9:0] d);
        step;
        step;
        adcDone = 1'b1;
        adcData = d;
        step;
        adcDone = 1'b0;
    endtask

    initial begin
        int n;
        int r0;
        resetN = 1'b0; recal = 1'b0; adcDone = 1'b0; adcData = '0;
        #12;
        chk("rst_req", {31'b0, adcReq}, 0);
        chk("rst_offset", {22'b0, offset}, 0);
        chk("rst_cal", {31'b0, calibrated}, 0);
        chk("rst_out", {21'b0, sampleOut}, 0);
        chk("rst_valid", {31'b0, sampleValid}, 0);
        @(posedge clk); #1;
        resetN = 1'b1;

        // Calibration: 100..103 averages to 101 (truncating).
        svSeen = 0;
        wait_req(n);
        chk("first_req_lat", n, 8);
        conv(10'd100);
        wait_req(n);
        chk("req_spacing", n, 5);
        conv(10'd101);
        wait_req(n);
        conv(10'd102);
        chk("cal_not_yet", {31'b0, calibrated}, 0);
        wait_req(n);
        conv(10'd103);
        chk("cal_offset", {22'b0, offset}, 101);
        chk("cal_done", {31'b0, calibrated}, 1);
        chk("cal_no_valid", svSeen, 0);

        // Run mode.
        wait_req(n);
        conv(10'd50);
        chk("run50_valid", {31'b0, sampleValid}, 1);
        chk("run50_out", {21'b0, sampleOut}, 32'h7CD);
        step;
        chk("valid_one_cycle", {31'b0, sampleValid}, 0);
        chk("out_hold", {21'b0, sampleOut}, 32'h7CD);
        wait_req(n);
        conv(10'd1023);
        chk("run1023_out", {21'b0, sampleOut}, 922);

        // Overrun: withhold adcDone for 20 cycles.
        wait_req(n);
        r0 = reqCount;
        repeat (20) step;
        chk("overrun_no_req", reqCount - r0, 0);
`ifdef SAMPLE_OVERRUN_COUNT_EN
        chk("overrun_count", {24'b0, overrunCount}, 2);
`endif
        adcDone = 1'b1; adcData = 10'd300;
        step;
        adcDone = 1'b0;
        chk("late_valid", {31'b0, sampleValid}, 1);
        chk("late_out", {21'b0, sampleOut}, 199);

        // Spurious done in RUN_IDLE.
        adcDone = 1'b1; adcData = 10'd7;
        step;
        adcDone = 1'b0;
        chk("spur_run_valid", {31'b0, sampleValid}, 0);
        chk("spur_run_out", {21'b0, sampleOut}, 199);

        // Recal coincident with run-mode done.
        wait_req(n);
        step;
        step;
        adcDone = 1'b1; adcData = 10'd500; recal = 1'b1;
        step;
        adcDone = 1'b0;
        chk("recal_valid", {31'b0, sampleValid}, 0);
        chk("recal_cal", {31'b0, calibrated}, 0);
        chk("recal_offset", {22'b0, offset}, 101);
`ifdef SAMPLE_OVERRUN_COUNT_EN
        chk("recal_overrun", {24'b0, overrunCount}, 0);
`endif
        r0 = reqCount;
        repeat (21) step;
        recal = 1'b0;
        chk("recal_hold_no_req", reqCount - r0, 0);

        // Spurious done in CAL_IDLE must not feed the average.
        adcDone = 1'b1; adcData = 10'd1023;
        step;
        adcDone = 1'b0;
        svSeen = 0;
        repeat (4) begin
            wait_req(n);
            conv(10'd200);
        end
        chk("recal_offset_new", {22'b0, offset}, 200);
        chk("recal_cal_new", {31'b0, calibrated}, 1);
        chk("recal_no_valid", svSeen, 0);

        // Async reset in the middle of CAL_WAIT.
        recal = 1'b1;
        step;
        recal = 1'b0;
        wait_req(n);
        step;
        #2 resetN = 1'b0;
        #1;
        chk("arst_offset", {22'b0, offset}, 0);
        chk("arst_cal", {31'b0, calibrated}, 0);
        chk("arst_req", {31'b0, adcReq}, 0);
        chk("arst_out", {21'b0, sampleOut}, 0);
        @(posedge clk); #1;
        resetN = 1'b1;
        wait_req(n);
        chk("arst_first_req", n, 8);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
